// File: rtl/sha256_pkg.sv
// Shared encodings for the double-SHA256 job sequencer and its datapath:
// command codes, select encodings, step-table entry and FSM states.
package sha256_pkg;

  localparam int unsigned CMD_W   = 8;
  localparam int unsigned MBLK_W  = 2;
  localparam int unsigned STEP_W  = 4;
  localparam int unsigned NONCE_W = 32;
  localparam int unsigned TMO_W   = 8;

  localparam logic [CMD_W-1:0] CMD_IDLE        = 8'd0;
  localparam logic [CMD_W-1:0] CMD_LOAD_H      = 8'd10;
  localparam logic [CMD_W-1:0] CMD_HASH        = 8'd20;
  localparam logic [CMD_W-1:0] CMD_SUM_STORE_H = 8'd30;
  localparam logic [CMD_W-1:0] CMD_SUM_STORE_M = 8'd40;

  localparam logic HSRC_IV  = 1'b0;
  localparam logic HSRC_MID = 1'b1;
  localparam logic HDST_MID = 1'b0;
  localparam logic HDST_RES = 1'b1;

  localparam logic [MBLK_W-1:0] MBLK_HDR0  = 2'd0;
  localparam logic [MBLK_W-1:0] MBLK_HDR1  = 2'd1;
  localparam logic [MBLK_W-1:0] MBLK_HASH2 = 2'd2;

  localparam logic [STEP_W-1:0] STEP_FIRST = 4'd0;
  localparam logic [STEP_W-1:0] STEP_MID   = 4'd3;
  localparam logic [STEP_W-1:0] STEP_LAST  = 4'd8;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic              hsrc;
    logic              hdst;
    logic [MBLK_W-1:0] mblk;
  } step_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_NEXT, S_DONE, S_ERR, S_DRAIN
  } state_e;

endpackage

// File: rtl/sha256_job_seq_if.sv
// Job/host and datapath handshake bundle of the sequencer; slave is the
// sequencer side, master the host/datapath side.
interface sha256_job_seq_if;
  import sha256_pkg::*;

  logic               START;
  logic               ABORT;
  logic [NONCE_W-1:0] NONCE_START;
  logic [NONCE_W-1:0] NONCE_END;
  logic               RDY;
  logic [CMD_W-1:0]   CMD;
  logic               HSRC;
  logic               HDST;
  logic [MBLK_W-1:0]  MBLK;
  logic [NONCE_W-1:0] NONCE;
  logic               BUSY;
  logic               HASH_VLD;
  logic               DONE;
  logic               ERR;

  modport slave (
    input  START, ABORT, NONCE_START, NONCE_END, RDY,
    output CMD, HSRC, HDST, MBLK, NONCE, BUSY, HASH_VLD, DONE, ERR
  );

  modport master (
    output START, ABORT, NONCE_START, NONCE_END, RDY,
    input  CMD, HSRC, HDST, MBLK, NONCE, BUSY, HASH_VLD, DONE, ERR
  );
endinterface

// File: rtl/sha256_step_rom.sv
// Step table: maps a step index to the command and the H-source,
// H-destination and message-block selects issued for it.
module sha256_step_rom
  import sha256_pkg::*;
(
  input  logic [STEP_W-1:0] step,
  output step_t             ent
);

  always_comb begin
    ent = '{cmd: CMD_IDLE, hsrc: HSRC_IV, hdst: HDST_MID, mblk: MBLK_HDR0};
    case (step)
      STEP_W'(0): ent = '{cmd: CMD_LOAD_H,      hsrc: HSRC_IV,  hdst: HDST_MID, mblk: MBLK_HDR0};
      STEP_W'(1): ent = '{cmd: CMD_HASH,        hsrc: HSRC_IV,  hdst: HDST_MID, mblk: MBLK_HDR0};
      STEP_W'(2): ent = '{cmd: CMD_SUM_STORE_H, hsrc: HSRC_IV,  hdst: HDST_MID, mblk: MBLK_HDR0};
      STEP_W'(3): ent = '{cmd: CMD_LOAD_H,      hsrc: HSRC_MID, hdst: HDST_MID, mblk: MBLK_HDR1};
      STEP_W'(4): ent = '{cmd: CMD_HASH,        hsrc: HSRC_MID, hdst: HDST_MID, mblk: MBLK_HDR1};
      STEP_W'(5): ent = '{cmd: CMD_SUM_STORE_M, hsrc: HSRC_MID, hdst: HDST_MID, mblk: MBLK_HDR1};
      STEP_W'(6): ent = '{cmd: CMD_LOAD_H,      hsrc: HSRC_IV,  hdst: HDST_RES, mblk: MBLK_HASH2};
      STEP_W'(7): ent = '{cmd: CMD_HASH,        hsrc: HSRC_IV,  hdst: HDST_RES, mblk: MBLK_HASH2};
      STEP_W'(8): ent = '{cmd: CMD_SUM_STORE_H, hsrc: HSRC_IV,  hdst: HDST_RES, mblk: MBLK_HASH2};
      default: ;
    endcase
  end

endmodule

// File: rtl/sha256_job_seq.sv
// Double-SHA256 nonce-search sequencer: walks the step table per nonce,
// reusing the block-0 midstate, with RDY handshake, timeout and abort drain.
module sha256_job_seq
  import sha256_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
)
(
  input  logic            CLK,
  input  logic            RST_N,
  sha256_job_seq_if.slave bus
);

  state_e             state;
  logic [STEP_W-1:0]  step;
  logic [NONCE_W-1:0] nonce;
  logic [NONCE_W-1:0] nonce_end;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [CMD_W-1:0]   cmd_q;
  logic               hsrc_q;
  logic               hdst_q;
  logic [MBLK_W-1:0]  mblk_q;
  logic               busy_q;
  logic               hash_vld_q;
  logic               done_q;
  logic               err_q;
  step_t              rom_ent;

  sha256_step_rom u_rom (
    .step (step),
    .ent  (rom_ent)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      step       <= STEP_FIRST;
      nonce      <= '0;
      nonce_end  <= '0;
      tmo_cnt    <= '0;
      cmd_q      <= CMD_IDLE;
      hsrc_q     <= HSRC_IV;
      hdst_q     <= HDST_MID;
      mblk_q     <= MBLK_HDR0;
      busy_q     <= 1'b0;
      hash_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      hash_vld_q <= 1'b0;
      done_q     <= 1'b0;
      if (bus.ABORT && state != S_IDLE && state != S_DRAIN) begin
        cmd_q <= CMD_IDLE;
        state <= S_DRAIN;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.START) begin
              state <= S_ISSUE;
              step  <= STEP_FIRST;
              nonce <= bus.NONCE_START;
              // A reversed range collapses to a single nonce
              nonce_end <= (bus.NONCE_START > bus.NONCE_END) ? bus.NONCE_START
                                                             : bus.NONCE_END;
              err_q <= 1'b0;
            end
          end
          S_ISSUE: begin
            cmd_q   <= rom_ent.cmd;
            hsrc_q  <= rom_ent.hsrc;
            hdst_q  <= rom_ent.hdst;
            mblk_q  <= rom_ent.mblk;
            busy_q  <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.RDY) begin
              state <= S_GAP;
            end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
              state <= S_ERR;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          S_GAP: begin
            cmd_q <= CMD_IDLE;
            if (!bus.RDY) begin
              if (step == STEP_LAST) begin
                hash_vld_q <= 1'b1;
                state      <= S_NEXT;
              end else begin
                step  <= step + STEP_W'(1);
                state <= S_ISSUE;
              end
            end
          end
          S_NEXT: begin
            // End check precedes increment so 0xFFFFFFFF never wraps
            if (nonce == nonce_end) begin
              state <= S_DONE;
            end else begin
              nonce <= nonce + NONCE_W'(1);
              step  <= STEP_MID;
              state <= S_ISSUE;
            end
          end
          S_DONE: begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
          S_ERR: begin
            cmd_q  <= CMD_IDLE;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
          S_DRAIN: begin
            cmd_q <= CMD_IDLE;
            if (!bus.RDY) begin
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Reset forces the command bus idle without waiting for a clock edge
  assign bus.CMD      = RST_N ? cmd_q : CMD_IDLE;
  assign bus.HSRC     = hsrc_q;
  assign bus.HDST     = hdst_q;
  assign bus.MBLK     = mblk_q;
  assign bus.NONCE    = nonce;
  assign bus.BUSY     = busy_q;
  assign bus.HASH_VLD = hash_vld_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;

endmodule

// File: doc/sha256_job_seq.md
# sha256_job_seq

Sequencer that drives the message-schedule/compression datapath's 8-bit command bus through a full double-SHA256 nonce search. It issues commands, waits on the datapath's RDY handshake and steers the H-value source, H destination and message-block selects. It computes the block-0 midstate once per job and reuses it for every nonce. It sits between the job/host interface (header buffers, nonce range) and the hashing datapath.

## Interface

Parameters:
- TIMEOUT, 255: max cycles in WAIT for RDY before error; 8-bit counter, 1..255.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST_N  in  1  synchronous reset, active-low.
- START  in  1  begin job; sampled only in S_IDLE.
- ABORT  in  1  cancel job; level, sampled every cycle.
- NONCE_START  in  32  first nonce; latched on START.
- NONCE_END  in  32  last nonce (inclusive); latched on START.
- RDY  in  1  datapath ready/done flag.
- CMD  out  8  datapath command: IDLE 0, LOAD_H 10, HASH 20, SUM_STORE_H 30, SUM_STORE_M 40.
- HSRC  out  1  H-value source mux: 0 = IV ROM, 1 = midstate buffer.
- HDST  out  1  SUM_STORE_H write target: 0 = midstate buffer, 1 = result register.
- MBLK  out  2  message buffer select: 0 = header block 0, 1 = header block 1 (with nonce), 2 = second-hash block.
- NONCE  out  32  nonce currently inserted into block 1.
- BUSY  out  1  job in progress.
- HASH_VLD  out  1  one-cycle pulse: result register holds digest for NONCE.
- DONE  out  1  one-cycle pulse: range exhausted.
- ERR  out  1  sticky timeout flag; cleared by next accepted START or reset.

## Operation

- Step table, index 0..8, as {CMD, HSRC, HDST, MBLK}:
  - 0: {LOAD_H, 0, 0, 0}
  - 1: {HASH, 0, 0, 0}
  - 2: {SUM_STORE_H, 0, 0, 0}
  - 3: {LOAD_H, 1, 0, 1}
  - 4: {HASH, 1, 0, 1}
  - 5: {SUM_STORE_M, 1, 0, 1}
  - 6: {LOAD_H, 0, 1, 2}
  - 7: {HASH, 0, 1, 2}
  - 8: {SUM_STORE_H, 0, 1, 2}
- First nonce runs steps 0–8. Each later nonce runs steps 3–8, reusing the midstate.
- States:
  - S_IDLE: on START go to S_ISSUE with step=0, NONCE=NONCE_START, ERR=0, BUSY=1.
  - S_ISSUE: drive the step's CMD and selects; next cycle go to S_WAIT and clear the timeout counter.
  - S_WAIT: hold CMD and selects. On RDY=1 go to S_GAP. If the counter reaches TIMEOUT, go to S_ERR.
  - S_GAP: CMD=IDLE; stay until RDY=0 (minimum 1 cycle). Then:
    - step<8: increment step, go to S_ISSUE.
    - step=8: go to S_NEXT.
  - S_NEXT: pulse HASH_VLD.
    - If NONCE==NONCE_END: go to S_DONE.
    - Else: NONCE+1 (mod 2^32), step=3, go to S_ISSUE.
  - S_DONE: pulse DONE, BUSY=0, go to S_IDLE.
  - S_ERR: CMD=IDLE, ERR=1, BUSY=0, go to S_IDLE.
- ABORT in any state except S_IDLE:
  - CMD=IDLE; enter a drain that waits for RDY=0, then go to S_IDLE.
  - BUSY=0 on entering S_IDLE. No DONE or HASH_VLD.
- START while BUSY is ignored. ABORT has priority over RDY in the same cycle.
- NONCE_START > NONCE_END: treated as a single-nonce run of NONCE_START.
- NONCE_END = 0xFFFFFFFF is legal; the wrap to 0 never occurs because the end check precedes the increment.

## Timing

- Reset values: CMD=0, HSRC=0, HDST=0, MBLK=0, NONCE=0, BUSY=0, HASH_VLD=0, DONE=0, ERR=0, state S_IDLE, step 0.
- START sampled at edge N: CMD=10 and BUSY=1 visible after edge N+1.
- RDY seen at edge M: CMD=0 after edge M+1.
- Every command is separated by at least one IDLE cycle. Selects stay stable through S_ISSUE, S_WAIT and S_GAP.
- Controller overhead per command: 3 cycles plus datapath latency. HASH_VLD lasts exactly 1 cycle, after the step-8 S_GAP.
- Timeout: ERR asserts TIMEOUT+1 cycles after S_WAIT entry if RDY stays 0.
- Reset mid-job: all outputs return to reset values at the next edge; CMD=0 immediately.

## Structure

- Shared package sha256_pkg holds:
  - CMD codes (0/10/20/30/40), matching the datapath's localparams.
  - HSRC/HDST/MBLK encodings.
  - State encodings.
- Sub-module sha256_step_rom: combinational, 4-bit step in, {CMD, HSRC, HDST, MBLK} out.
- Top module holds the FSM, nonce counter and timeout counter.

## Test plan

- Single nonce (START with 5..5, RDY model answers 4 cycles after each nonzero CMD):
  - CMD sequence is 10,20,30,10,20,40,10,20,30, with 0 between each.
  - One HASH_VLD with NONCE=5, then DONE, BUSY=0.
- Range 0..2:
  - Nonce 0 issues 9 commands; nonces 1 and 2 issue 6 each, starting with CMD=10 and HSRC=1.
  - 3 HASH_VLD pulses with NONCE 0,1,2.
- TIMEOUT=16, RDY held 0 after first CMD: ERR=1 at 17 cycles after S_WAIT entry; CMD=0, BUSY=0, no DONE.
- ABORT during step 4 (HASH) with RDY=0:
  - CMD=0 next cycle, BUSY=0, no HASH_VLD.
  - A new START then restarts at step 0.
- RST_N=0 mid-job for 1 cycle: all outputs at reset values the following cycle; START while BUSY is ignored.
- NONCE_START=0xFFFFFFFF, NONCE_END=0xFFFFFFFF: one HASH_VLD, DONE, NONCE stays 0xFFFFFFFF.
